// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   HEX7_TABLE : active-high segment codes {g,f,e,d,c,b,a} for nibbles 0..F
//   pol_apply  : invert a pin vector when the pins are active-low
package seg_pkg;

   localparam int unsigned SEG_W = 8;
   localparam int unsigned POL_W = 16;

   localparam logic [6:0] HEX7_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Callers widen to POL_W and cast the result back to their pin width.
   function automatic logic [POL_W-1:0] pol_apply(input logic [POL_W-1:0] v,
                                                  input logic             active_low);
      return active_low ? ~v : v;
   endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bus/pin bundle for seg_scan_driver.
//   master : register side, drives en/load/data/dp/blank/lzs, sees pins
//   slave  : the driver, receives the register fields, drives seg/an/frame_tick
interface seg_scan_driver_if #(
   parameter int unsigned DIGITS = 8
) ();

   logic                  en;
   logic                  load;
   logic [4*DIGITS-1:0]   data;
   logic [DIGITS-1:0]     dp;
   logic [DIGITS-1:0]     blank;
   logic                  lzs;
   logic [7:0]            seg;
   logic [DIGITS-1:0]     an;
   logic                  frame_tick;

   modport master (
      output en, load, data, dp, blank, lzs,
      input  seg, an, frame_tick
   );

   modport slave (
      input  en, load, data, dp, blank, lzs,
      output seg, an, frame_tick
   );

endinterface

// File: rtl/hex7_encode.sv
// Combinational hex nibble to seven-segment lookup.
//   nib   : 4-bit value
//   seg_c : active-high segments {g,f,e,d,c,b,a}
module hex7_encode
   import seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg_c
);

   assign seg_c = HEX7_TABLE[nib];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed DIGITS-digit seven-segment driver with a shadow register,
// leading-zero suppression, per-digit blanking and selectable pin polarity.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave modport; register fields in, seg/an/frame_tick out
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned DIGITS         = 8,
   parameter int unsigned SCAN_DIV       = 50000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   seg_scan_driver_if.slave   bus
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [PW-1:0]     PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [SEG_W-1:0]  SEG_OFF    = SEG_ACTIVE_LOW ? '1 : '0;
   localparam logic [DIGITS-1:0] AN_OFF     = AN_ACTIVE_LOW ? '1 : '0;

   logic [PW-1:0]        presc;
   logic [IW-1:0]        idx;
   logic [4*DIGITS-1:0]  sh_data;
   logic [DIGITS-1:0]    sh_dp;
   logic [DIGITS-1:0]    sh_blank;
   logic                 sh_lzs;

   logic [3:0]           nib_c;
   logic                 dp_c;
   logic                 blank_c;
   logic                 upper_zero_c;
   logic                 supp_c;
   logic [DIGITS-1:0]    an_hot_c;
   logic [6:0]           hex_c;
   logic [SEG_W-1:0]     seg_act_c;
   logic [SEG_W-1:0]     seg_next_c;
   logic [DIGITS-1:0]    an_next_c;
   logic                 presc_wrap_c;

   // Select the current digit's fields; upper_zero_c is true when this and
   // every more-significant nibble is zero.
   always_comb begin
      nib_c        = 4'h0;
      dp_c         = 1'b0;
      blank_c      = 1'b0;
      upper_zero_c = 1'b1;
      an_hot_c     = '0;
      for (int j = 0; j < int'(DIGITS); j++) begin
         if (IW'(j) == idx) begin
            nib_c       = sh_data[4*j +: 4];
            dp_c        = sh_dp[j];
            blank_c     = sh_blank[j];
            an_hot_c[j] = 1'b1;
         end
         if ((IW'(j) >= idx) && (sh_data[4*j +: 4] != 4'h0)) begin
            upper_zero_c = 1'b0;
         end
      end
      // Digit 0 is exempt from zero suppression so a zero value still shows "0".
      supp_c = blank_c || (sh_lzs && (idx != '0) && upper_zero_c);
   end

   hex7_encode u_hex7_encode (
      .nib   (nib_c),
      .seg_c (hex_c)
   );

   // Pin values for the next output update, polarity applied.
   always_comb begin
      seg_act_c    = supp_c ? '0 : {dp_c, hex_c};
      seg_next_c   = SEG_W'(pol_apply(POL_W'(seg_act_c), SEG_ACTIVE_LOW));
      an_next_c    = DIGITS'(pol_apply(POL_W'(an_hot_c), AN_ACTIVE_LOW));
      presc_wrap_c = (presc == PRESC_LAST);
   end

   // Shadow capture, scan counters, frame pulse and registered pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc          <= '0;
         idx            <= '0;
         sh_data        <= '0;
         sh_dp          <= '0;
         sh_blank       <= '0;
         sh_lzs         <= 1'b0;
         bus.frame_tick <= 1'b0;
         bus.seg        <= SEG_OFF;
         bus.an         <= AN_OFF;
      end else begin
         if (bus.load) begin
            sh_data  <= bus.data;
            sh_dp    <= bus.dp;
            sh_blank <= bus.blank;
            sh_lzs   <= bus.lzs;
         end

         if (!bus.en) begin
            presc          <= '0;
            idx            <= '0;
            bus.frame_tick <= 1'b0;
         end else if (presc_wrap_c) begin
            presc          <= '0;
            idx            <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            bus.frame_tick <= (idx == IDX_LAST);
         end else begin
            presc          <= presc + 1'b1;
            bus.frame_tick <= 1'b0;
         end

         if (!bus.en) begin
            bus.seg <= SEG_OFF;
            bus.an  <= AN_OFF;
         end else begin
            bus.seg <= seg_next_c;
            bus.an  <= an_next_c;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed, scoreboard-based bench for seg_scan_driver: a 4-digit / divide-by-3
// instance and a 1-digit / divide-by-1 instance, both pin polarities active-low.
module tb_seg_scan_driver;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   seg_scan_driver_if #(.DIGITS(4)) bus ();
   seg_scan_driver_if #(.DIGITS(1)) bus1 ();

   seg_scan_driver #(
      .DIGITS(4), .SCAN_DIV(3), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   seg_scan_driver #(
      .DIGITS(1), .SCAN_DIV(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   typedef struct {
      logic [7:0] seg;
      logic [3:0] an;
   } exp_t;

   exp_t sbq [$];
   int   ncmp = 0;
   int   nerr = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      ncmp++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] seg, input logic [3:0] an);
      exp_t e;
      e.seg = seg;
      e.an  = an;
      sbq.push_back(e);
   endtask

   // Wait for the first cycle in which an newly equals target.
   task automatic wait_an(input logic [3:0] target, input string tag);
      int n = 0;
      while (bus.an === target && n < 40) begin tick(); n++; end
      while (bus.an !== target && n < 40) begin tick(); n++; end
      check({tag, "_wait"}, 16'(n < 40), 16'd1);
   endtask

   // Wait for a frame_tick pulse so that the next digit-0 dwell is a fresh frame.
   task automatic sync_frame(input string tag);
      int n = 0;
      while (bus.frame_tick !== 1'b1 && n < 40) begin tick(); n++; end
      check({tag, "_sync"}, 16'(n < 40), 16'd1);
   endtask

   // Pop one expected entry per digit and compare at the start of its dwell.
   task automatic check_frame(input string tag);
      exp_t e;
      for (int d = 0; d < 4; d++) begin
         if (sbq.size() == 0) begin
            check($sformatf("%s_sbq_empty", tag), 16'd0, 16'd1);
            return;
         end
         e = sbq.pop_front();
         wait_an(e.an, $sformatf("%s_d%0d", tag, d));
         check($sformatf("%s_an%0d", tag, d), 16'(bus.an), 16'(e.an));
         check($sformatf("%s_seg%0d", tag, d), 16'(bus.seg), 16'(e.seg));
      end
   endtask

   task automatic load_word(input logic [15:0] data, input logic [3:0] dp,
                            input logic [3:0] blank, input logic lzs);
      bus.data  = data;
      bus.dp    = dp;
      bus.blank = blank;
      bus.lzs   = lzs;
      bus.load  = 1'b1;
      tick();
      bus.load  = 1'b0;
   endtask

   initial begin
      int n;

      rst_n     = 1'b0;
      bus.en    = 1'b1;
      bus.load  = 1'b0;
      bus.data  = '0;
      bus.dp    = '0;
      bus.blank = '0;
      bus.lzs   = 1'b0;
      bus1.en    = 1'b1;
      bus1.load  = 1'b0;
      bus1.data  = '0;
      bus1.dp    = '0;
      bus1.blank = '0;
      bus1.lzs   = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_seg", 16'(bus.seg), 16'h00FF);
      check("rst_an", 16'(bus.an), 16'h000F);
      check("rst_ft", 16'(bus.frame_tick), 16'd0);
      check("rst1_seg", 16'(bus1.seg), 16'h00FF);
      check("rst1_an", 16'(bus1.an), 16'h0001);
      check("rst1_ft", 16'(bus1.frame_tick), 16'd0);

      // Release: first update shows digit 0 = "0"; 1-digit instance ticks every cycle
      rst_n = 1'b1;
      tick();
      check("rel_an", 16'(bus.an), 16'h000E);
      check("rel_seg", 16'(bus.seg), 16'h00C0);
      check("d1_seg", 16'(bus1.seg), 16'h00C0);
      check("d1_an", 16'(bus1.an), 16'h0000);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("d1_ft%0d", i), 16'(bus1.frame_tick), 16'd1);
         tick();
      end

      // No load: all digits show 0, 3-cycle dwell
      push_exp(8'hC0, 4'hE); push_exp(8'hC0, 4'hD);
      push_exp(8'hC0, 4'hB); push_exp(8'hC0, 4'h7);
      check_frame("zero");
      wait_an(4'hD, "dwell");
      n = 0;
      while (bus.an === 4'hD && n < 10) begin tick(); n++; end
      check("dwell_len", 16'(n), 16'd3);

      // Load and scan
      load_word(16'h1A3F, 4'b0010, 4'b0000, 1'b0);
      sync_frame("ld");
      push_exp(8'h8E, 4'hE); push_exp(8'h30, 4'hD);
      push_exp(8'h88, 4'hB); push_exp(8'hF9, 4'h7);
      check_frame("ld");

      // frame_tick: one cycle wide, period 12
      sync_frame("ftp");
      tick();
      check("ft_width", 16'(bus.frame_tick), 16'd0);
      n = 1;
      while (bus.frame_tick !== 1'b1 && n < 30) begin tick(); n++; end
      check("ft_period", 16'(n), 16'd12);

      // Leading-zero suppression
      load_word(16'h0030, 4'b0000, 4'b0000, 1'b1);
      sync_frame("lzs");
      push_exp(8'hC0, 4'hE); push_exp(8'hB0, 4'hD);
      push_exp(8'hFF, 4'hB); push_exp(8'hFF, 4'h7);
      check_frame("lzs");

      load_word(16'h0000, 4'b0000, 4'b0000, 1'b1);
      sync_frame("lzs0");
      push_exp(8'hC0, 4'hE); push_exp(8'hFF, 4'hD);
      push_exp(8'hFF, 4'hB); push_exp(8'hFF, 4'h7);
      check_frame("lzs0");

      // Blank hides the digit and its dp
      load_word(16'h8888, 4'b0100, 4'b0100, 1'b0);
      sync_frame("blk");
      push_exp(8'h80, 4'hE); push_exp(8'h80, 4'hD);
      push_exp(8'hFF, 4'hB); push_exp(8'h80, 4'h7);
      check_frame("blk");

      // Load coincident with idx advance: old digit on that edge, new data next
      wait_an(4'hE, "coin");
      tick();
      check("coin_pre_an", 16'(bus.an), 16'h000E);
      check("coin_pre_seg", 16'(bus.seg), 16'h0080);
      load_word(16'h1234, 4'b0000, 4'b0000, 1'b0);
      check("coin_edge_an", 16'(bus.an), 16'h000E);
      check("coin_edge_seg", 16'(bus.seg), 16'h0080);
      tick();
      check("coin_new_an", 16'(bus.an), 16'h000D);
      check("coin_new_seg", 16'(bus.seg), 16'h00B0);
      sync_frame("w1234");
      push_exp(8'h99, 4'hE); push_exp(8'hB0, 4'hD);
      push_exp(8'hA4, 4'hB); push_exp(8'hF9, 4'h7);
      check_frame("w1234");

      // Drop en during digit 2, then re-enable
      wait_an(4'hB, "endrop");
      bus.en = 1'b0;
      tick();
      check("en0_an", 16'(bus.an), 16'h000F);
      check("en0_seg", 16'(bus.seg), 16'h00FF);
      check("en0_ft", 16'(bus.frame_tick), 16'd0);
      tick();
      check("en0_an_hold", 16'(bus.an), 16'h000F);
      bus.en = 1'b1;
      tick();
      check("en1_an", 16'(bus.an), 16'h000E);
      check("en1_seg", 16'(bus.seg), 16'h0099);

      // Asynchronous reset mid-dwell
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("arst_an", 16'(bus.an), 16'h000F);
      check("arst_seg", 16'(bus.seg), 16'h00FF);
      check("arst1_seg", 16'(bus1.seg), 16'h00FF);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_an", 16'(bus.an), 16'h000E);
      check("post_rst_seg", 16'(bus.seg), 16'h00C0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed driver for a DIGITS-digit common-anode/cathode seven-segment display.
- Double-buffers a packed hex word plus per-digit decimal points and blank masks, then scans one digit per SCAN_DIV clocks.
- Adds optional leading-zero suppression and polarity selection.
- Sits between the CPU/IO bus register and the board display pins; it is the parametrised successor of the single-digit hex decoder.

Parameters:
- DIGITS, 8, number of digits scanned (1..16)
- SCAN_DIV, 50000, clocks per digit dwell (>=1)
- SEG_ACTIVE_LOW, 1, 1 = seg pins driven low to light
- AN_ACTIVE_LOW, 1, 1 = anode/select pins driven low to enable

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  scan enable
- load  in  1  one-cycle strobe; captures data/dp/blank/lzs into shadow
- data  in  4*DIGITS  hex nibbles; digit i = data[4i+3:4i], digit 0 rightmost
- dp  in  DIGITS  decimal point per digit, 1 = lit
- blank  in  DIGITS  force digit dark, 1 = blank
- lzs  in  1  leading-zero suppression enable
- seg  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- an  out  DIGITS  one-hot digit select, polarity per AN_ACTIVE_LOW
- frame_tick  out  1  one-cycle pulse when scan index wraps DIGITS-1 -> 0

Behaviour:
- Reset (rst_n=0, asynchronous): prescaler=0, idx=0, shadow data/dp/blank/lzs=0, frame_tick=0. seg and an are all-inactive (all 1 when active-low).
- Load: on a clock edge with load=1, shadow captures all four inputs. Unloaded inputs have no effect on the display.
- Prescaler: counts 0..SCAN_DIV-1 while en=1. On the edge where it equals SCAN_DIV-1, it wraps to 0 and idx advances (DIGITS-1 wraps to 0).
- frame_tick: registered, high for exactly the cycle after idx wraps to 0. For DIGITS=1, it pulses on every prescaler wrap.
- SCAN_DIV=1: idx advances every cycle.
- en=0: prescaler and idx synchronously clear to 0; an and seg go all-inactive on the next edge; frame_tick=0. On re-enable, the scan restarts at digit 0.
- Output register:
  - Each cycle, seg and an are registered from (idx, shadow, en): one-cycle latency from an idx change to the pins.
  - an = one-hot(idx), polarity applied.
  - seg[6:0] = hex code of shadow nibble idx, unless that digit is suppressed, in which case it is 0 (dark).
  - seg[7] = shadow dp[idx], unless suppressed.
- Hex code (active-high, bit0=a): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Suppression: digit i is suppressed if blank[i]=1, or if lzs=1 and all nibbles j>=i are 0 with i!=0. Digit 0 is never LZS-blanked. A suppressed digit also hides its dp.
- Simultaneous load and idx advance: both take effect; the new shadow is visible from the next output update.
- Reset mid-scan: outputs go inactive immediately (asynchronous), without waiting for a clock edge.
- Widths: prescaler = max(1, clog2(SCAN_DIV)); idx = max(1, clog2(DIGITS)). No counter may exceed its terminal value.

Decomposition:
- Shared package seg_pkg: the 16-entry hex-to-segment constant table, and a polarity-apply function.
- Sub-module hex7_encode: a combinational 4-bit in, 7-bit out lookup using the package table.
- seg_scan_driver instantiates one hex7_encode on the muxed nibble; all sequential logic stays in the top.

Test Plan:
- Bench parameters: DIGITS=4, SCAN_DIV=3, both polarities active-low.
- Reset/no load: hold rst_n=0, then release with en=1. Required: seg=FF and an=F during reset. After release, an walks E,D,B,7 every 3 cycles with seg=C0 (hex 0, active-low).
- Load and scan: load data=0x1A3F, dp=0010. Required per digit: idx0 seg=8E (F); idx1 seg=30 (3 with dp lit, 0x4F|0x80 inverted); idx2 seg=88 (A); idx3 seg=F9 (1). frame_tick pulses once every 12 cycles.
- LZS: load data=0x0030, lzs=1. Required: digits 3 and 2 seg=FF; digit 1 shows 3 (B0); digit 0 shows 0 (C0). Repeat with data=0x0000: only digit 0 shows C0.
- Blank and dp: load blank=0100, dp=0100, data=0x8888. Required: digit 2 seg=FF (dp hidden); other digits seg=80.
- Enable/reset mid-scan: drop en during idx=2. Required: outputs inactive one edge later, and scan restarts at an=E on re-enable. Then assert rst_n=0 mid-dwell: seg/an go inactive without a clock edge.
- Coincident load: pulse load on the idx-advance edge. Required: the new value appears on the pins at the next output update with no glitch value. Also run DIGITS=1, SCAN_DIV=1: frame_tick is high every cycle after the first.
